fetch_unit: RTL and testbench

//  Instruction-fetch front end that feeds the Control decoder.
//  - Holds the PC and issues requests to instruction memory over a request/acknowledge handshake.
//  - Presents the fetched word, its PC and its 10-bit opcode field to decode.
//  - Computes the next PC from the 3-bit Jump code that Control produces and the ALU flags.
//  - Takes a flush input from exception/debug logic and redirects the PC to it.

---
 rtl/fetch_unit.sv | 159 +++++++++++++++
 tb/tb_fetch_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, runs the imem request/ack handshake,
// holds one fetched instruction for decode and resolves the next PC from the Jump code.
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
    parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(32'd4)
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [9:0]         op,
    output logic [ADDR_W-1:0]  pc,
    output logic               instr_valid,
    input  logic               instr_accept,
    input  logic [2:0]         jump,
    input  logic               zero,
    input  logic               neg,
    input  logic [ADDR_W-1:0]  br_target,
    input  logic [ADDR_W-1:0]  jr_target,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  flush_pc,
    output logic               illegal_jump
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } stateT;

    stateT               state, stateNext;
    logic [ADDR_W-1:0]   fetchPc, fetchPcNext;
    logic [ADDR_W-1:0]   flushPcLat, flushPcLatNext;
    logic                flushPend, flushPendNext;
    logic [INSTR_W-1:0]  instrNext;
    logic [ADDR_W-1:0]   pcNext;
    logic                validNext;
    logic                illegalNext;
    logic                imemReqNext;

    function automatic logic [ADDR_W-1:0] calcNextPc(
        input logic [2:0]        jumpCode,
        input logic              zeroFlag,
        input logic              negFlag,
        input logic [ADDR_W-1:0] curPc,
        input logic [ADDR_W-1:0] brTgt,
        input logic [ADDR_W-1:0] jrTgt
    );
        logic [ADDR_W-1:0] seqPc;
        seqPc = curPc + PC_STEP;
        case (jumpCode)
            3'd0:    calcNextPc = brTgt;
            3'd1:    calcNextPc = zeroFlag ? brTgt : seqPc;
            3'd2:    calcNextPc = zeroFlag ? seqPc : brTgt;
            3'd3:    calcNextPc = negFlag  ? brTgt : seqPc;
            3'd4:    calcNextPc = negFlag  ? seqPc : brTgt;
            3'd5:    calcNextPc = jrTgt;
            default: calcNextPc = seqPc;
        endcase
    endfunction

    assign op = instr[INSTR_W-1 -: 10];

    // Next-state and next-output logic; flush always outranks ack, accept and jump.
    always_comb begin
        stateNext      = state;
        fetchPcNext    = fetchPc;
        flushPcLatNext = flushPcLat;
        flushPendNext  = flushPend;
        instrNext      = instr;
        pcNext         = pc;
        validNext      = instr_valid;
        illegalNext    = 1'b0;
        case (state)
            BOOT: begin
                stateNext = FETCH;
                if (flush) begin
                    fetchPcNext = flush_pc;
                end else begin
                    fetchPcNext = fetchPc;
                end
            end
            FETCH: begin
                if (imem_ack) begin
                    // A flush seen now or while waiting turns this beat into a discard.
                    if (flush) begin
                        fetchPcNext   = flush_pc;
                        flushPendNext = 1'b0;
                    end else if (flushPend) begin
                        fetchPcNext   = flushPcLat;
                        flushPendNext = 1'b0;
                    end else begin
                        instrNext = imem_rdata;
                        pcNext    = fetchPc;
                        validNext = 1'b1;
                        stateNext = HOLD;
                    end
                end else if (flush) begin
                    // Address must stay put until ack, so the redirect waits here.
                    flushPendNext  = 1'b1;
                    flushPcLatNext = flush_pc;
                end else begin
                    flushPendNext = flushPend;
                end
            end
            HOLD: begin
                if (flush) begin
                    validNext   = 1'b0;
                    fetchPcNext = flush_pc;
                    stateNext   = FETCH;
                end else if (instr_accept) begin
                    validNext   = 1'b0;
                    fetchPcNext = calcNextPc(jump, zero, neg, pc, br_target, jr_target);
                    illegalNext = (jump == 3'd7);
                    stateNext   = FETCH;
                end else begin
                    stateNext = HOLD;
                end
            end
            default: begin
                stateNext = BOOT;
            end
        endcase
        imemReqNext = (stateNext == FETCH);
    end

    // State and output registers; reset drops imem_req immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= BOOT;
            fetchPc      <= RESET_PC;
            flushPcLat   <= {ADDR_W{1'b0}};
            flushPend    <= 1'b0;
            imem_req     <= 1'b0;
            imem_addr    <= RESET_PC;
            instr        <= {INSTR_W{1'b0}};
            pc           <= {ADDR_W{1'b0}};
            instr_valid  <= 1'b0;
            illegal_jump <= 1'b0;
        end else begin
            state        <= stateNext;
            fetchPc      <= fetchPcNext;
            flushPcLat   <= flushPcLatNext;
            flushPend    <= flushPendNext;
            imem_req     <= imemReqNext;
            imem_addr    <= fetchPcNext;
            instr        <= instrNext;
            pc           <= pcNext;
            instr_valid  <= validNext;
            illegal_jump <= illegalNext;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by randomized jump/flag/target traffic,
// checked against a transaction-level next-PC model and a hashed instruction memory.
module tb_fetch_unit;

    localparam int AW = 32;
    localparam int IW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack = 1'b0;
    logic [IW-1:0] imem_rdata = '0;
    logic [IW-1:0] instr;
    logic [9:0]    op;
    logic [AW-1:0] pc;
    logic          instr_valid;
    logic          instr_accept = 1'b0;
    logic [2:0]    jump = 3'd6;
    logic          zero = 1'b0;
    logic          neg = 1'b0;
    logic [AW-1:0] br_target = '0;
    logic [AW-1:0] jr_target = '0;
    logic          flush = 1'b0;
    logic [AW-1:0] flush_pc = '0;
    logic          illegal_jump;

    int checks = 0;
    int errors = 0;
    logic [AW-1:0] modelPc;
    logic [AW-1:0] expNext;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .op(op), .pc(pc), .instr_valid(instr_valid), .instr_accept(instr_accept),
        .jump(jump), .zero(zero), .neg(neg), .br_target(br_target), .jr_target(jr_target),
        .flush(flush), .flush_pc(flush_pc), .illegal_jump(illegal_jump)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] memWord(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Architectural next-PC rule: taken branches go to br_target, register jumps to jr_target.
    function automatic logic [AW-1:0] refNext(input logic [AW-1:0] cur, input logic [2:0] j,
                                              input logic z, input logic n,
                                              input logic [AW-1:0] br, input logic [AW-1:0] jr);
        logic taken;
        if (j == 3'd5) return jr;
        taken = (j == 3'd0) || (j == 3'd1 && z) || (j == 3'd2 && !z) ||
                (j == 3'd3 && n) || (j == 3'd4 && !n);
        return taken ? br : cur + 32'd4;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait for a request, check its address, ack after lat cycles, then check the held result.
    task automatic fetchCycle(input logic [AW-1:0] expAddr, input int lat);
        int waited;
        logic [IW-1:0] w;
        waited = 0;
        while (imem_req !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("req_seen", {63'd0, imem_req}, 64'd1);
        chk("req_addr", {32'd0, imem_addr}, {32'd0, expAddr});
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            chk("addr_stable", {32'd0, imem_addr}, {32'd0, expAddr});
            chk("valid_low_fetch", {63'd0, instr_valid}, 64'd0);
        end
        imem_ack = 1'b1;
        imem_rdata = memWord(imem_addr);
        @(negedge clk);
        imem_ack = 1'b0;
        imem_rdata = $urandom;
        w = memWord(expAddr);
        chk("valid_rise", {63'd0, instr_valid}, 64'd1);
        chk("pc", {32'd0, pc}, {32'd0, expAddr});
        chk("instr", {32'd0, instr}, {32'd0, w});
        chk("op", {54'd0, op}, {54'd0, w[31:22]});
        chk("req_low_hold", {63'd0, imem_req}, 64'd0);
        modelPc = expAddr;
    endtask

    // Sit in HOLD for stall cycles, then accept with the given control; ends one cycle into the next fetch.
    task automatic acceptStep(input logic [2:0] j, input logic z, input logic n,
                              input logic [AW-1:0] br, input logic [AW-1:0] jr, input int stall,
                              output logic [AW-1:0] nxt);
        nxt = refNext(modelPc, j, z, n, br, jr);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("hold_valid", {63'd0, instr_valid}, 64'd1);
            chk("hold_pc", {32'd0, pc}, {32'd0, modelPc});
        end
        chk("valid_before_accept", {63'd0, instr_valid}, 64'd1);
        instr_accept = 1'b1;
        jump = j; zero = z; neg = n; br_target = br; jr_target = jr;
        @(negedge clk);
        instr_accept = 1'b0;
        jump = 3'($urandom); zero = 1'($urandom); neg = 1'($urandom);
        br_target = $urandom; jr_target = $urandom;
        chk("valid_drop", {63'd0, instr_valid}, 64'd0);
        chk("illegal_pulse", {63'd0, illegal_jump}, {63'd0, (j == 3'd7)});
        chk("req_next", {63'd0, imem_req}, 64'd1);
        chk("addr_next", {32'd0, imem_addr}, {32'd0, nxt});
        @(negedge clk);
        chk("illegal_clear", {63'd0, illegal_jump}, 64'd0);
    endtask

    initial begin
        modelPc = '0;
        repeat (2) @(negedge clk);
        chk("rst_req", {63'd0, imem_req}, 64'd0);
        chk("rst_addr", {32'd0, imem_addr}, 64'd0);
        chk("rst_valid", {63'd0, instr_valid}, 64'd0);
        chk("rst_pc", {32'd0, pc}, 64'd0);
        chk("rst_instr", {32'd0, instr}, 64'd0);
        chk("rst_illegal", {63'd0, illegal_jump}, 64'd0);

        // Boot fetch and sequential step
        rst_n = 1'b1;
        @(negedge clk);
        fetchCycle(32'h0, 0);
        acceptStep(3'd6, 1'b0, 1'b0, 32'h0, 32'h0, 1, expNext);
        fetchCycle(expNext, 1);

        // Conditional branch on zero, taken then not taken
        acceptStep(3'd1, 1'b1, 1'b0, 32'h100, 32'h0, 0, expNext);
        fetchCycle(expNext, 0);
        acceptStep(3'd1, 1'b0, 1'b0, 32'h200, 32'h0, 2, expNext);
        fetchCycle(expNext, 2);

        // Register jump, then illegal code
        acceptStep(3'd5, 1'b0, 1'b0, 32'h0, 32'h3C, 0, expNext);
        fetchCycle(expNext, 0);
        acceptStep(3'd7, 1'b1, 1'b1, 32'h500, 32'h600, 0, expNext);
        fetchCycle(expNext, 0);

        // PC wrap-around
        acceptStep(3'd5, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC, 0, expNext);
        fetchCycle(expNext, 0);
        acceptStep(3'd6, 1'b0, 1'b0, 32'h0, 32'h0, 0, expNext);
        fetchCycle(expNext, 0);

        // Flush during FETCH, ack three cycles later
        acceptStep(3'd6, 1'b0, 1'b0, 32'h0, 32'h0, 0, expNext);
        flush = 1'b1; flush_pc = 32'h80;
        @(negedge clk);
        flush = 1'b0;
        chk("pend_addr_hold", {32'd0, imem_addr}, {32'd0, expNext});
        chk("pend_req_hold", {63'd0, imem_req}, 64'd1);
        repeat (2) begin
            @(negedge clk);
            chk("pend_addr_hold", {32'd0, imem_addr}, {32'd0, expNext});
        end
        imem_ack = 1'b1; imem_rdata = memWord(imem_addr);
        @(negedge clk);
        imem_ack = 1'b0;
        chk("pend_drop_valid", {63'd0, instr_valid}, 64'd0);
        chk("pend_redirect", {32'd0, imem_addr}, 64'h80);
        fetchCycle(32'h80, 0);

        // Second flush overwrites the pending redirect
        acceptStep(3'd6, 1'b0, 1'b0, 32'h0, 32'h0, 0, expNext);
        flush = 1'b1; flush_pc = 32'h90;
        @(negedge clk);
        flush_pc = 32'hA0;
        @(negedge clk);
        flush = 1'b0;
        chk("overwrite_hold", {32'd0, imem_addr}, {32'd0, expNext});
        imem_ack = 1'b1; imem_rdata = memWord(imem_addr);
        @(negedge clk);
        imem_ack = 1'b0;
        chk("overwrite_valid", {63'd0, instr_valid}, 64'd0);
        chk("overwrite_addr", {32'd0, imem_addr}, 64'hA0);
        fetchCycle(32'hA0, 1);

        // Flush coincident with ack
        acceptStep(3'd6, 1'b0, 1'b0, 32'h0, 32'h0, 0, expNext);
        imem_ack = 1'b1; imem_rdata = memWord(imem_addr);
        flush = 1'b1; flush_pc = 32'hC0;
        @(negedge clk);
        imem_ack = 1'b0; flush = 1'b0;
        chk("ackflush_valid", {63'd0, instr_valid}, 64'd0);
        chk("ackflush_req", {63'd0, imem_req}, 64'd1);
        chk("ackflush_addr", {32'd0, imem_addr}, 64'hC0);
        fetchCycle(32'hC0, 0);

        // Flush beats accept in HOLD
        instr_accept = 1'b1; jump = 3'd0; br_target = 32'h200;
        flush = 1'b1; flush_pc = 32'h300;
        @(negedge clk);
        instr_accept = 1'b0; flush = 1'b0;
        chk("holdflush_valid", {63'd0, instr_valid}, 64'd0);
        chk("holdflush_addr", {32'd0, imem_addr}, 64'h300);
        chk("holdflush_illegal", {63'd0, illegal_jump}, 64'd0);
        fetchCycle(32'h300, 2);

        // Reset during an outstanding request
        acceptStep(3'd6, 1'b0, 1'b0, 32'h0, 32'h0, 0, expNext);
        #2 rst_n = 1'b0;
        #1 chk("async_req_drop", {63'd0, imem_req}, 64'd0);
        chk("async_valid", {63'd0, instr_valid}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        fetchCycle(32'h0, 0);

        // Flush in BOOT
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; flush = 1'b1; flush_pc = 32'h500;
        @(negedge clk);
        flush = 1'b0;
        chk("boot_flush_addr", {32'd0, imem_addr}, 64'h500);
        fetchCycle(32'h500, 0);

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(7, 0) == 0) begin
                flush = 1'b1; flush_pc = $urandom;
                instr_accept = 1'($urandom);
                expNext = flush_pc;
                @(negedge clk);
                flush = 1'b0; instr_accept = 1'b0;
                chk("rnd_flush_valid", {63'd0, instr_valid}, 64'd0);
                chk("rnd_flush_addr", {32'd0, imem_addr}, {32'd0, expNext});
            end else begin
                acceptStep(3'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom,
                           $urandom_range(2, 0), expNext);
            end
            fetchCycle(expNext, $urandom_range(3, 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
